host_cmd_sequencer: RTL and testbench

HOST_CMD_SEQUENCER -- requirements
Module: host_cmd_sequencer

---
 rtl/host_cmd_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_host_cmd_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_cmd_sequencer.sv
// host_cmd_sequencer: turns one host request (write / read / run) into a
// doorbell-strobed command for the control unit, tracks the control unit
// status through completion (and halt acknowledge for run), then presents a
// single response to the host.
// Optional feature macro: HOST_SEQ_TIMEOUT_EN bounds the BUSY/HALTED waits by
// TIMEOUT_CYCLES and reports expiry through rsp_error.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef ARG_WIDTH
`define ARG_WIDTH 32
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH 32
`endif
`ifndef HOST_DATA_WIDTH
`define HOST_DATA_WIDTH 8
`endif
`ifndef STATUS_IDLE
`define STATUS_IDLE 8'h00
`endif
`ifndef STATUS_BUSY
`define STATUS_BUSY 8'h01
`endif
`ifndef STATUS_HALTED
`define STATUS_HALTED 8'h02
`endif
`ifndef CMD_WRITE_MEM
`define CMD_WRITE_MEM 8'h01
`endif
`ifndef CMD_READ_MEM
`define CMD_READ_MEM 8'h02
`endif
`ifndef CMD_RUN
`define CMD_RUN 8'h03
`endif

module host_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [`ADDR_WIDTH-1:0]        req_addr,
  input  logic [`ARG_WIDTH-1:0]         req_arg,
  input  logic [`BUFFER_WIDTH-1:0]      req_wdata,
  output logic [`HOST_DATA_WIDTH-1:0]   cmd_out,
  output logic [`ADDR_WIDTH-1:0]        addr_out,
  output logic [`ARG_WIDTH-1:0]         arg_out,
  output logic [`BUFFER_WIDTH-1:0]      mmvr_out,
  output logic                          doorbell_pulse,
  input  logic [`HOST_DATA_WIDTH-1:0]   status_in,
  input  logic [`BUFFER_WIDTH-1:0]      rd_data_in,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [`BUFFER_WIDTH-1:0]      rsp_rdata,
  output logic                          rsp_error
);

  // The wait counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("host_cmd_sequencer: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_HALT_ACK,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_RUN   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  state_e                        state_q;
  op_e                           op_q;
  logic [`HOST_DATA_WIDTH-1:0]   cmd_q;
  logic [`ADDR_WIDTH-1:0]        addr_q;
  logic [`ARG_WIDTH-1:0]         arg_q;
  logic [`BUFFER_WIDTH-1:0]      wdata_q;
  logic                          doorbell_q;
  logic                          req_ready_q;
  logic                          rsp_valid_q;
  logic                          rsp_error_q;
  logic [`BUFFER_WIDTH-1:0]      rsp_rdata_q;

`ifdef HOST_SEQ_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt_q;
`endif

  function automatic logic [`HOST_DATA_WIDTH-1:0] op_to_cmd(input op_e op);
    case (op)
      OP_WRITE: op_to_cmd = `CMD_WRITE_MEM;
      OP_READ:  op_to_cmd = `CMD_READ_MEM;
      OP_RUN:   op_to_cmd = `CMD_RUN;
      default:  op_to_cmd = '0;
    endcase
  endfunction

  // Request/response FSM; every output is a register updated here.
  // The doorbell is raised on the edge that enters S_WAIT_BUSY / S_HALT_ACK,
  // so its one-cycle strobe coincides with the first cycle of those states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_WRITE;
      cmd_q       <= '0;
      addr_q      <= '0;
      arg_q       <= '0;
      wdata_q     <= '0;
      doorbell_q  <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef HOST_SEQ_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      doorbell_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            op_q        <= op_e'(req_op);
            cmd_q       <= op_to_cmd(op_e'(req_op));
            addr_q      <= req_addr;
            arg_q       <= req_arg;
            wdata_q     <= req_wdata;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            if (op_e'(req_op) == OP_RSVD) begin
              rsp_error_q <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (status_in == `STATUS_IDLE) begin
            doorbell_q <= 1'b1;
            state_q    <= S_WAIT_BUSY;
`ifdef HOST_SEQ_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end
        end
        S_WAIT_BUSY: begin
`ifdef HOST_SEQ_TIMEOUT_EN
          wait_cnt_q <= wait_cnt_q + 16'd1;
`endif
          if (status_in != `STATUS_IDLE) begin
            state_q <= S_WAIT_DONE;
`ifdef HOST_SEQ_TIMEOUT_EN
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == TIMEOUT_LAST) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
`endif
          end
        end
        S_WAIT_DONE: begin
`ifdef HOST_SEQ_TIMEOUT_EN
          wait_cnt_q <= wait_cnt_q + 16'd1;
`endif
          if ((op_q == OP_RUN) ? (status_in == `STATUS_HALTED)
                               : (status_in == `STATUS_IDLE)) begin
            if (op_q == OP_RUN) begin
              doorbell_q <= 1'b1;
              state_q    <= S_HALT_ACK;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              if (op_q == OP_READ) begin
                rsp_rdata_q <= rd_data_in;
              end
            end
`ifdef HOST_SEQ_TIMEOUT_EN
          end else if (wait_cnt_q == TIMEOUT_LAST) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
`endif
          end
        end
        S_HALT_ACK: begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign cmd_out        = cmd_q;
  assign addr_out       = addr_q;
  assign arg_out        = arg_q;
  assign mmvr_out       = wdata_q;
  assign doorbell_pulse = doorbell_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_error      = rsp_error_q;
  assign rsp_rdata      = rsp_rdata_q;

endmodule

// File: tb/tb_host_cmd_sequencer.sv
// Bench for host_cmd_sequencer: a behavioural control-unit model answers the
// doorbells, a vector table drives write/read/run/reserved requests, and a
// scoreboard queue holds the expected response of each request.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef ARG_WIDTH
`define ARG_WIDTH 32
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH 32
`endif
`ifndef HOST_DATA_WIDTH
`define HOST_DATA_WIDTH 8
`endif
`ifndef STATUS_IDLE
`define STATUS_IDLE 8'h00
`endif
`ifndef STATUS_BUSY
`define STATUS_BUSY 8'h01
`endif
`ifndef STATUS_HALTED
`define STATUS_HALTED 8'h02
`endif
`ifndef CMD_WRITE_MEM
`define CMD_WRITE_MEM 8'h01
`endif
`ifndef CMD_READ_MEM
`define CMD_READ_MEM 8'h02
`endif
`ifndef CMD_RUN
`define CMD_RUN 8'h03
`endif

module tb_host_cmd_sequencer;

  localparam int AW = `ADDR_WIDTH;
  localparam int RW = `ARG_WIDTH;
  localparam int BW = `BUFFER_WIDTH;
  localparam int HW = `HOST_DATA_WIDTH;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [AW-1:0] req_addr = '0;
  logic [RW-1:0] req_arg = '0;
  logic [BW-1:0] req_wdata = '0;
  logic [HW-1:0] cmd_out;
  logic [AW-1:0] addr_out;
  logic [RW-1:0] arg_out;
  logic [BW-1:0] mmvr_out;
  logic          doorbell_pulse;
  logic [HW-1:0] status_in = `STATUS_IDLE;
  logic [BW-1:0] rd_data_in = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [BW-1:0] rsp_rdata;
  logic          rsp_error;

  host_cmd_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_arg        (req_arg),
    .req_wdata      (req_wdata),
    .cmd_out        (cmd_out),
    .addr_out       (addr_out),
    .arg_out        (arg_out),
    .mmvr_out       (mmvr_out),
    .doorbell_pulse (doorbell_pulse),
    .status_in      (status_in),
    .rd_data_in     (rd_data_in),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_error      (rsp_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Control-unit model: BUSY one cycle after a doorbell for cu_busy_len
  // cycles, then IDLE (returning cu_rd) or HALTED; a doorbell while HALTED
  // is the halt acknowledge and returns it to IDLE.
  int            cu_busy_len = 1;
  bit            cu_halt = 1'b0;
  bit            cu_force = 1'b0;
  bit            cu_clr = 1'b0;
  logic [BW-1:0] cu_rd = '0;
  int            busy_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n || cu_clr) begin
      status_in <= `STATUS_IDLE;
      busy_cnt  <= 0;
    end else if (cu_force) begin
      status_in <= `STATUS_BUSY;
      busy_cnt  <= 1;
    end else if (doorbell_pulse) begin
      if (status_in == `STATUS_HALTED) begin
        status_in <= `STATUS_IDLE;
      end else begin
        status_in <= `STATUS_BUSY;
        busy_cnt  <= cu_busy_len;
      end
    end else if (status_in == `STATUS_BUSY) begin
      if (busy_cnt <= 1) begin
        status_in  <= cu_halt ? `STATUS_HALTED : `STATUS_IDLE;
        rd_data_in <= cu_rd;
      end else begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  // Doorbell monitor: counts strobes, checks no back-to-back strobes and
  // that the command presented with each strobe is the expected one.
  int            db_cnt = 0;
  logic          db_prev = 1'b0;
  logic [HW-1:0] cur_cmd = '0;

  always @(negedge clk) begin
    if (doorbell_pulse) begin
      db_cnt++;
      check("db_consecutive", {63'd0, db_prev}, 64'd0);
      check("db_cmd", {{(64-HW){1'b0}}, cmd_out}, {{(64-HW){1'b0}}, cur_cmd});
    end
    db_prev = doorbell_pulse;
  end

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [RW-1:0] arg;
    logic [BW-1:0] wdata;
    logic [BW-1:0] rd;
    int            busy;
    bit            halt;
    logic [HW-1:0] cmd;
    logic [BW-1:0] rdata;
    bit            err;
    int            db;
    int            lat;
  } vec_t;

  typedef struct {
    logic [HW-1:0] cmd;
    logic [AW-1:0] addr;
    logic [RW-1:0] arg;
    logic [BW-1:0] wdata;
    logic [BW-1:0] rdata;
    bit            err;
    bit            chk_cmd;
    int            db;
    int            lat;
  } exp_t;

  exp_t sb[$];

  function automatic vec_t mk(input logic [1:0] op, input logic [AW-1:0] addr,
                              input logic [RW-1:0] arg, input logic [BW-1:0] wdata,
                              input logic [BW-1:0] rd, input int busy, input bit halt,
                              input logic [HW-1:0] cmd, input logic [BW-1:0] rdata,
                              input bit err, input int db, input int lat);
    vec_t v;
    v.op = op; v.addr = addr; v.arg = arg; v.wdata = wdata; v.rd = rd;
    v.busy = busy; v.halt = halt; v.cmd = cmd; v.rdata = rdata;
    v.err = err; v.db = db; v.lat = lat;
    return v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_req", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic drive_req(input vec_t v);
    exp_t e;
    cu_busy_len = v.busy;
    cu_halt     = v.halt;
    cu_rd       = v.rd;
    cur_cmd     = v.cmd;
    req_op      = v.op;
    req_addr    = v.addr;
    req_arg     = v.arg;
    req_wdata   = v.wdata;
    req_valid   = 1'b1;
    e.cmd = v.cmd; e.addr = v.addr; e.arg = v.arg; e.wdata = v.wdata;
    e.rdata = v.rdata; e.err = v.err; e.chk_cmd = (v.op != 2'd3);
    e.db = v.db; e.lat = v.lat;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = ~v.addr;
    req_arg   = ~v.arg;
    req_wdata = ~v.wdata;
    req_op    = 2'd0;
    check("ready_low_after_accept", {63'd0, req_ready}, 64'd0);
  endtask

  // One full transaction; pre_busy holds status BUSY after acceptance,
  // hold keeps rsp_ready low that many cycles once the response appears.
  task automatic do_txn(input vec_t v, input int hold, input int pre_busy);
    int   lat;
    int   db0;
    exp_t e;
    wait_ready();
    db0 = db_cnt;
    drive_req(v);
    for (int i = 0; i < pre_busy; i++) begin
      check("no_db_while_busy", {63'd0, doorbell_pulse}, 64'd0);
      @(negedge clk);
    end
    if (pre_busy > 0) begin
      check("db_count_while_busy", 64'(db_cnt - db0), 64'd0);
      cu_force = 1'b0;
    end
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      if (e.lat >= 0) check("rsp_latency", 64'(lat), 64'(e.lat));
      check("rsp_error", {63'd0, rsp_error}, {63'd0, e.err});
      check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
      check("doorbell_count", 64'(db_cnt - db0), 64'(e.db));
      if (e.chk_cmd) begin
        check("cmd_out", 64'(cmd_out), 64'(e.cmd));
        check("addr_out", 64'(addr_out), 64'(e.addr));
        check("arg_out", 64'(arg_out), 64'(e.arg));
        check("mmvr_out", 64'(mmvr_out), 64'(e.wdata));
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_valid_held", {63'd0, rsp_valid}, 64'd1);
      check("req_ready_low_in_resp", {63'd0, req_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_cleared", {63'd0, rsp_valid}, 64'd0);
    check("req_ready_after_rsp", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_doorbell"}, {63'd0, doorbell_pulse}, 64'd0);
    check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    check({tag, "_rsp_error"}, {63'd0, rsp_error}, 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_cmd"}, 64'(cmd_out), 64'd0);
    check({tag, "_addr"}, 64'(addr_out), 64'd0);
    check({tag, "_arg"}, 64'(arg_out), 64'd0);
    check({tag, "_mmvr"}, 64'(mmvr_out), 64'd0);
    check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt[8];
  vec_t v;

  initial begin
    // Latency (negedges after the accepting edge): write/read 3+busy,
    // run 4+busy (halt acknowledge cycle), reserved op 0.
    vt[0] = mk(2'd0, 16'h0010, 32'h0, 32'hA5A5A5A5, 32'h0, 1, 1'b0,
               `CMD_WRITE_MEM, 32'h0, 1'b0, 1, 4);
    vt[1] = mk(2'd1, 16'h0020, 32'h0, 32'h0, 32'h00001234, 1, 1'b0,
               `CMD_READ_MEM, 32'h00001234, 1'b0, 1, 4);
    vt[2] = mk(2'd2, 16'h0000, 32'h5, 32'h0, 32'h0, 20, 1'b1,
               `CMD_RUN, 32'h0, 1'b0, 2, 24);
    vt[3] = mk(2'd3, 16'h0040, 32'h9, 32'h11, 32'h0, 1, 1'b0,
               8'h00, 32'h0, 1'b1, 0, 0);
    vt[4] = mk(2'd1, 16'hBEEF, 32'h0, 32'h0, 32'hDEADBEEF, 3, 1'b0,
               `CMD_READ_MEM, 32'hDEADBEEF, 1'b0, 1, 6);
    vt[5] = mk(2'd0, 16'hFFFF, 32'h0, 32'hFFFFFFFF, 32'h55AA55AA, 2, 1'b0,
               `CMD_WRITE_MEM, 32'h0, 1'b0, 1, 5);
    vt[6] = mk(2'd2, 16'h0001, 32'hFFFF0123, 32'h0, 32'h0, 1, 1'b1,
               `CMD_RUN, 32'h0, 1'b0, 2, 5);
    vt[7] = mk(2'd3, 16'h0002, 32'h0, 32'h0, 32'h0, 1, 1'b0,
               8'h00, 32'h0, 1'b1, 0, 0);

    // Reset state, then req_ready on the first edge after release.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("req_ready_first_edge", {63'd0, req_ready}, 64'd1);

    for (int i = 0; i < 8; i++) begin
      do_txn(vt[i], 0, 0);
    end

    // Request while the control unit is busy, then a stalled response.
    cu_force = 1'b1;
    repeat (2) @(negedge clk);
    v = mk(2'd0, 16'h0123, 32'h0, 32'hCAFEF00D, 32'h0, 2, 1'b0,
           `CMD_WRITE_MEM, 32'h0, 1'b0, 1, -1);
    do_txn(v, 4, 6);

    // Reset while waiting for run completion, then a normal request.
    wait_ready();
    v = mk(2'd2, 16'h0000, 32'h7, 32'h0, 32'h0, 50, 1'b1,
           `CMD_RUN, 32'h0, 1'b0, 2, -1);
    drive_req(v);
    void'(sb.pop_back());
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midop_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    v = mk(2'd1, 16'h0077, 32'h0, 32'h0, 32'h0BADC0DE, 2, 1'b0,
           `CMD_READ_MEM, 32'h0BADC0DE, 1'b0, 1, 5);
    do_txn(v, 1, 0);

`ifdef HOST_SEQ_TIMEOUT_EN
    // Status stuck BUSY: response with error after TO cycles in S_WAIT_DONE.
    v = mk(2'd0, 16'h0099, 32'h0, 32'h12345678, 32'h0, 1000, 1'b0,
           `CMD_WRITE_MEM, 32'h0, 1'b1, 1, 3 + TO);
    do_txn(v, 0, 0);
    cu_clr = 1'b1;
    @(negedge clk);
    cu_clr = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
